// File: rtl/mode_sequencer.sv
// mode_sequencer: command front end for the mode-controlled datapath controller.
// Commands (mode, length, operand) are queued in a small FIFO, then replayed one
// at a time as the exact on/start waveform the controller expects. The block
// follows the controller's regime until it is back in the off state, and then
// reports done. A command is aborted with err if the controller does not enter
// the requested regime.
//
// Optional build macro MODE_SEQ_TIMEOUT_EN: bounds the DRAIN wait to TIMEOUT
// cycles. When the bound expires the command is aborted with err.
// Without the macro, DRAIN waits for regime==0 indefinitely.
//
// on/start/busy/done/x are flops aligned with the state register. err depends
// on the regime input sampled in the same cycle, so it is a decode of the
// current state and input.

module mode_sequencer #(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       cmd_x,
    input  logic [1:0]       regime,
    output logic [1:0]       on,
    output logic             start,
    output logic [7:0]       x,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 10 + LEN_W;
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    localparam logic [1:0] MODE_NOP   = 2'd0;
    localparam logic [1:0] MODE_ENUM  = 2'd1;
    localparam logic [1:0] MODE_COUNT = 2'd2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_DELAY  = 3'd3;
    localparam logic [2:0] S_PULSE  = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;
    localparam logic [2:0] S_DRAIN  = 3'd6;
    localparam logic [2:0] S_FINISH = 3'd7;

    // FIFO storage and pointers
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [EW-1:0]    head_s;
    logic             full_s, empty_s, push_s, pop_s;

    // Sequencer state and the command being replayed
    logic [2:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       x_q, x_d;

    // Output flops
    logic [1:0]       on_q, on_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_s;

`ifdef MODE_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]    tmo_q, tmo_d;
`endif

    assign full_s    = (count_q == FULL_CNT);
    assign empty_s   = (count_q == {(AW+1){1'b0}});
    assign cmd_ready = rst & ~full_s;
    assign push_s    = cmd_valid & cmd_ready;
    assign pop_s     = (state_q == S_IDLE) & ~empty_s & (regime == 2'd0);
    assign head_s    = mem_q[rd_ptr_q];

    assign on    = on_q;
    assign start = start_q;
    assign x     = x_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_s & rst;

    // FIFO next-state: write on push, advance read on pop, track occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {cmd_mode, cmd_len, cmd_x};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer next-state: pop, issue, check, shape start, drain, finish
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        err_s   = 1'b0;
`ifdef MODE_SEQ_TIMEOUT_EN
        tmo_d   = {TW{1'b0}};
`endif
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    {mode_d, len_d, x_d} = head_s;
                    state_d = (head_s[EW-1 -: 2] == MODE_NOP) ? S_FINISH : S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_CHECK;
            S_CHECK: begin
                if (regime != mode_q) begin
                    err_s   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    case (mode_q)
                        MODE_ENUM: begin
                            if (len_q != LEN_ZERO) begin
                                cnt_d   = len_q;
                                state_d = S_DELAY;
                            end else begin
                                state_d = S_PULSE;
                            end
                        end
                        MODE_COUNT: begin
                            // CHECK already carries the first start cycle
                            if (len_q > LEN_ONE) begin
                                cnt_d   = len_q - LEN_ONE;
                                state_d = S_HOLD;
                            end else begin
                                state_d = S_DRAIN;
                            end
                        end
                        default: state_d = S_DRAIN;
                    endcase
                end
            end
            S_DELAY: begin
                if (cnt_q == LEN_ONE) begin
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q - LEN_ONE;
                end
            end
            S_PULSE: state_d = S_DRAIN;
            S_HOLD: begin
                if (cnt_q == LEN_ONE) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q - LEN_ONE;
                end
            end
            S_DRAIN: begin
                if (regime == 2'd0) begin
                    state_d = S_FINISH;
                end else begin
`ifdef MODE_SEQ_TIMEOUT_EN
                    if (tmo_q == TMO_LAST) begin
                        err_s   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
`else
                    state_d = S_DRAIN;
`endif
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode of the next state so the output flops line up with the state
    always_comb begin
        on_d    = (state_d == S_ISSUE) ? mode_d : 2'd0;
        start_d = (state_d == S_PULSE) || (state_d == S_HOLD) ||
                  ((state_d == S_CHECK) && (mode_d == MODE_COUNT) && (len_d != LEN_ZERO));
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_FINISH);
    end

    // State, FIFO and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            state_q  <= S_IDLE;
            mode_q   <= 2'd0;
            len_q    <= LEN_ZERO;
            cnt_q    <= LEN_ZERO;
            x_q      <= 8'd0;
            on_q     <= 2'd0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            mode_q   <= mode_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            on_q     <= on_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef MODE_SEQ_TIMEOUT_EN
    // DRAIN cycle counter, cleared in every other state
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_q <= {TW{1'b0}};
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer. The reference model derives each
// command's expected waveform from its timeline rules (issue, check, active
// start phase, drain, finish) using arithmetic on the cycle index.
module tb_mode_sequencer;

`ifdef MODE_SEQ_TIMEOUT_EN
    localparam int TMO = 32;
`else
    localparam int TMO = 1 << 20;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_len;
    logic [7:0] cmd_x;
    logic [1:0] regime;
    logic [1:0] on;
    logic       start;
    logic [7:0] x;
    logic       busy;
    logic       done;
    logic       err;

    logic [1:0] regime_tb;
    logic [1:0] regime_auto;
    logic       auto_ctl;
    int         hold_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_x;

    logic       mon_en;
    int         mon_err;
    logic [7:0] done_x[$];

    // expected / observed {on,start,busy,done,err,x} per cycle, regime schedule
    logic [13:0] e_vec[128];
    logic [13:0] o_vec[128];
    logic [1:0]  sched[128];

    assign regime = auto_ctl ? regime_auto : regime_tb;

    always #5 clk = ~clk;

    mode_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_len(cmd_len), .cmd_x(cmd_x), .regime(regime),
        .on(on), .start(start), .x(x), .busy(busy), .done(done), .err(err)
    );

    // simple reactive controller: enters the requested regime, leaves it later
    always @(posedge clk) begin
        if (!auto_ctl) begin
            regime_auto <= 2'd0;
            hold_cnt    <= 0;
        end else if (on != 2'd0) begin
            regime_auto <= on;
            hold_cnt    <= 2;
        end else if (hold_cnt != 0) begin
            hold_cnt <= hold_cnt - 1;
        end else begin
            regime_auto <= 2'd0;
        end
    end

    // completion monitor for the back-to-back scenario
    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) done_x.push_back(x);
            if (err === 1'b1) mon_err = mon_err + 1;
        end
    end

    // reference model: cycle 0 is the pop cycle, cycle 1 is ISSUE for real modes
    task automatic model(input int m, input int len, input int xv, input int xprev,
                         input int mis, input int mval, input int w, output int n);
        int a, t_done, t_err, b_end;
        logic [1:0] on_e, r_e;
        logic st_e;
        a      = (m == 1) ? len + 2 : (m == 2) ? ((len > 1) ? len : 1) : 1;
        t_done = -1;
        t_err  = -1;
        if (m == 0) begin
            t_done = 1; b_end = 1; n = 3;
        end else if (mis != 0) begin
            t_err = 2; b_end = 2; n = 4;
        end else if (w >= TMO) begin
            t_err = 1 + a + TMO; b_end = t_err; n = a + w + 3;
        end else begin
            t_done = 3 + a + w; b_end = t_done; n = t_done + 2;
        end
        for (int i = 0; i < n; i++) begin
            on_e = (m != 0 && i == 1) ? 2'(m) : 2'd0;
            st_e = 1'b0;
            if (i <= b_end && m == 1 && i == 3 + len) st_e = 1'b1;
            if (i <= b_end && m == 2 && i >= 2 && i <= 1 + len) st_e = 1'b1;
            e_vec[i] = {on_e, st_e, (i >= 1 && i <= b_end), (i == t_done), (i == t_err),
                        (i == 0) ? 8'(xprev) : 8'(xv)};
            r_e = 2'd0;
            if (m != 0) begin
                if (mis != 0) r_e = (i == 2) ? 2'(mval) : 2'd0;
                else          r_e = (i >= 2 && i <= a + w + 1) ? 2'(m) : 2'd0;
            end
            sched[i] = r_e;
        end
    endtask

    // push one command into an idle DUT, then play the regime schedule and record outputs
    task automatic play_cmd(input int m, input int len, input int xv, input int n);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode  = 2'(m);
        cmd_len   = 4'(len);
        cmd_x     = 8'(xv);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            regime_tb = sched[i];
            @(negedge clk);
            o_vec[i] = {on, start, busy, done, err, x};
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_len = 4'd0; cmd_x = 8'd0;
        regime_tb = 2'd0; auto_ctl = 1'b0; mon_en = 1'b0; mon_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({on, start, busy, done, err, x} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {on, start, busy, done, err, x});
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", cmd_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release {ready,busy}: got %b want 10", {cmd_ready, busy});
        end
        last_x = 8'd0;
    endtask

    task automatic test_modes();
        int tm[9] = '{3, 1, 1, 2, 2, 0, 2, 3, 1};
        int tl[9] = '{0, 0, 3, 5, 0, 7, 1, 15, 15};
        int tx[9] = '{'h5A, 'h11, 'h22, 'h33, 'h44, 'h55, 'h66, 'h77, 'h88};
        int tw[9] = '{3, 6, 6, 1, 1, 0, 0, 40, 2};
        int n;
        for (int r = 0; r < 9; r++) begin
            model(tm[r], tl[r], tx[r], int'(last_x), 0, 0, tw[r], n);
            play_cmd(tm[r], tl[r], tx[r], n);
            for (int i = 0; i < n; i++) begin
                checks++;
                if (o_vec[i] !== e_vec[i]) begin
                    errors++;
                    $display("FAIL modes row %0d cycle %0d {on,start,busy,done,err,x}: got %b want %b",
                             r, i, o_vec[i], e_vec[i]);
                end
            end
            last_x = 8'(tx[r]);
        end
    endtask

    task automatic test_mismatch();
        int tm[3]  = '{2, 3, 1};
        int tl[3]  = '{4, 2, 2};
        int tx[3]  = '{'hA1, 'hB2, 'hC3};
        int tmi[3] = '{1, 0, 1};
        int tmv[3] = '{0, 0, 3};
        int n;
        for (int r = 0; r < 3; r++) begin
            model(tm[r], tl[r], tx[r], int'(last_x), tmi[r], tmv[r], 2, n);
            play_cmd(tm[r], tl[r], tx[r], n);
            for (int i = 0; i < n; i++) begin
                checks++;
                if (o_vec[i] !== e_vec[i]) begin
                    errors++;
                    $display("FAIL mismatch row %0d cycle %0d {on,start,busy,done,err,x}: got %b want %b",
                             r, i, o_vec[i], e_vec[i]);
                end
            end
            last_x = 8'(tx[r]);
        end
    endtask

    task automatic test_random();
        int m, len, xv, mis, mval, w, n;
        for (int r = 0; r < 30; r++) begin
            m    = int'($urandom_range(0, 3));
            len  = int'($urandom_range(0, 15));
            xv   = int'($urandom_range(0, 255));
            mis  = (m != 0 && $urandom_range(0, 5) == 0) ? 1 : 0;
            mval = (m + int'($urandom_range(1, 3))) % 4;
            w    = int'($urandom_range(0, 8));
            model(m, len, xv, int'(last_x), mis, mval, w, n);
            play_cmd(m, len, xv, n);
            for (int i = 0; i < n; i++) begin
                checks++;
                if (o_vec[i] !== e_vec[i]) begin
                    errors++;
                    $display("FAIL random iter %0d (m=%0d len=%0d mis=%0d w=%0d) cycle %0d: got %b want %b",
                             r, m, len, mis, w, i, o_vec[i], e_vec[i]);
                end
            end
            last_x = 8'(xv);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] xs[5];
        int got;
        for (int k = 0; k < 5; k++) xs[k] = 8'($urandom_range(0, 255));
        done_x.delete();
        mon_err   = 0;
        mon_en    = 1'b1;
        regime_tb = 2'd1;   // controller busy: IDLE cannot pop while filling
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: got %b want 1", k, cmd_ready);
            end
            cmd_valid = 1'b1;
            cmd_mode  = 2'($urandom_range(0, 3));
            cmd_len   = 4'($urandom_range(0, 5));
            cmd_x     = xs[k];
            @(posedge clk); #1;
        end
        cmd_mode = 2'($urandom_range(0, 3));
        cmd_len  = 4'($urandom_range(0, 5));
        cmd_x    = xs[4];
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_full {ready,busy}: got %b want 00", {cmd_ready, busy});
        end
        regime_tb = 2'd0;
        auto_ctl  = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                got = 1;
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (got != 1) begin
            errors++;
            $display("FAIL b2b_fifth_accept: got %0d want 1", got);
        end
        for (int c = 0; c < 400 && done_x.size() < 5; c++) @(negedge clk);
        repeat (12) @(negedge clk);
        checks++;
        if (done_x.size() != 5) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d want 5", done_x.size());
        end
        checks++;
        if (mon_err != 0) begin
            errors++;
            $display("FAIL b2b_err_count: got %0d want 0", mon_err);
        end
        for (int k = 0; k < 5 && k < done_x.size(); k++) begin
            checks++;
            if (done_x[k] !== xs[k]) begin
                errors++;
                $display("FAIL b2b_order_%0d x: got %h want %h", k, done_x[k], xs[k]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle busy: got %b want 0", busy);
        end
        mon_en   = 1'b0;
        auto_ctl = 1'b0;
        last_x   = xs[4];
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 2'd2; cmd_len = 4'd10; cmd_x = 8'h33;
        @(posedge clk); #1;
        cmd_mode = 2'd0; cmd_len = 4'd0; cmd_x = 8'h77;   // queued behind the count
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        regime_tb = 2'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({start, busy, x} !== {2'b11, 8'h33}) begin
            errors++;
            $display("FAIL midrst_hold {start,busy,x}: got %b want %b", {start, busy, x}, {2'b11, 8'h33});
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({on, start, busy, done, err, x, cmd_ready} !== 15'd0) begin
            errors++;
            $display("FAIL midrst_state {on,start,busy,done,err,x,ready}: got %b want 0",
                     {on, start, busy, done, err, x, cmd_ready});
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready_low: got %b want 0", cmd_ready);
        end
        regime_tb = 2'd0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready_back: got %b want 1", cmd_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_flushed cycle %0d busy: got %b want 0", c, busy);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_modes();
        test_mismatch();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
